// File: rtl/armleocpu_axi_sram_pkg.sv
// Shared AXI constants, FSM encodings and the access legality check for the SRAM responder.
// Latency: none, pure definitions.
// Backpressure: not applicable.
package armleocpu_axi_sram_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

   // Write FSM encodings
   localparam logic [1:0] WR_ADDR = 2'd0;
   localparam logic [1:0] WR_DATA = 2'd1;
   localparam logic [1:0] WR_RESP = 2'd2;

   // Read FSM encodings
   localparam logic [0:0] RD_ADDR = 1'b0;
   localparam logic [0:0] RD_RESP = 1'b1;

   // A single aligned word beat that falls inside the SRAM window is legal.
   function automatic logic axi_access_legal(
      input logic [31:0] addr,
      input logic [7:0]  len,
      input logic [2:0]  size,
      input logic [31:0] base,
      input int          depth_log2
   );
      logic [31:0] addr_hi;
      logic [31:0] base_hi;
      addr_hi = addr >> (depth_log2 + 2);
      base_hi = base >> (depth_log2 + 2);
      return (len == 8'd0) && (size == AXI_SIZE_WORD) &&
             (addr[1:0] == 2'b00) && (addr_hi == base_hi);
   endfunction

endpackage

// File: rtl/armleocpu_mem_1w1r.sv
// One write port with byte enables, one read port with a registered output.
// Latency: read data valid one clk after re; writes land at the clk edge.
// Backpressure: none; rdata holds its value until the next re.
module armleocpu_mem_1w1r #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [3:0]            wbe,
   input  logic [31:0]           wdata,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [31:0]           rdata
);

   localparam int WORDS = 1 << DEPTH_LOG2;

   logic [31:0] mem [WORDS];

   // Byte-masked write; storage is intentionally not reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we && wbe[i]) begin
            mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // Registered read; a same-cycle write to raddr returns the old word
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/armleocpu_axi_sram.sv
// AXI4 single-beat responder over a word SRAM, independent read and write FSMs, SLVERR on illegal access.
// Latency: AW->B two cycles minimum (W may follow AW by one), AR->R one cycle.
// Backpressure: B and R outputs hold stable until BREADY/RREADY; new addresses wait in the address states.
module armleocpu_axi_sram
   import armleocpu_axi_sram_pkg::*;
#(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   input  logic [31:0] S_AXI_AWADDR,
   input  logic [7:0]  S_AXI_AWLEN,
   input  logic [2:0]  S_AXI_AWSIZE,
   input  logic [1:0]  S_AXI_AWBURST,
   input  logic        S_AXI_AWLOCK,
   input  logic [2:0]  S_AXI_AWPROT,

   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   input  logic [31:0] S_AXI_WDATA,
   input  logic [3:0]  S_AXI_WSTRB,
   input  logic        S_AXI_WLAST,

   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY,
   output logic [1:0]  S_AXI_BRESP,
   output logic        S_AXI_BUSER,

   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   input  logic [31:0] S_AXI_ARADDR,
   input  logic [7:0]  S_AXI_ARLEN,
   input  logic [2:0]  S_AXI_ARSIZE,
   input  logic [1:0]  S_AXI_ARBURST,
   input  logic        S_AXI_ARLOCK,
   input  logic [2:0]  S_AXI_ARPROT,

   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY,
   output logic [31:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic        S_AXI_RLAST,
   output logic        S_AXI_RUSER
);

   // Write channel state
   logic [1:0]            wr_state;
   logic                  wr_legal;
   logic [DEPTH_LOG2-1:0] wr_word;
   logic [1:0]            bresp;

   // Read channel state
   logic [0:0]            rd_state;
   logic                  rd_legal;
   logic [7:0]            rd_len;
   logic [7:0]            rd_cnt;
   logic [1:0]            rresp;
   logic                  rlast;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  b_hs;
   logic                  ar_hs;
   logic                  r_hs;
   logic                  aw_legal;
   logic                  ar_legal;

   logic                  mem_we;
   logic                  mem_re;
   logic [31:0]           mem_rdata;

   // Burst type, lock and protection carry no meaning for this memory
   logic unused_axi_attrs;
   assign unused_axi_attrs = ^{S_AXI_AWBURST, S_AXI_AWLOCK, S_AXI_AWPROT,
                               S_AXI_ARBURST, S_AXI_ARLOCK, S_AXI_ARPROT};

   assign aw_legal = axi_access_legal(S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, BASE_ADDR, DEPTH_LOG2);
   assign ar_legal = axi_access_legal(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, BASE_ADDR, DEPTH_LOG2);

   // Ready/valid gated by rst_n so nothing is offered while reset is held
   assign S_AXI_AWREADY = rst_n && (wr_state == WR_ADDR);
   assign S_AXI_WREADY  = rst_n && (wr_state == WR_DATA);
   assign S_AXI_BVALID  = rst_n && (wr_state == WR_RESP);
   assign S_AXI_ARREADY = rst_n && (rd_state == RD_ADDR);
   assign S_AXI_RVALID  = rst_n && (rd_state == RD_RESP);

   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
   assign b_hs  = S_AXI_BVALID  && S_AXI_BREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
   assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;

   assign S_AXI_BRESP = bresp;
   assign S_AXI_BUSER = 1'b0;
   assign S_AXI_RRESP = rresp;
   assign S_AXI_RLAST = rlast;
   assign S_AXI_RUSER = 1'b0;
   // The SRAM output is only refreshed by legal reads, so error beats force zero
   assign S_AXI_RDATA = rd_legal ? mem_rdata : 32'h0;

   // Error writes absorb their beats without touching storage
   assign mem_we = w_hs && wr_legal;
   assign mem_re = ar_hs && ar_legal;

   armleocpu_mem_1w1r #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_word),
      .wbe   (S_AXI_WSTRB),
      .wdata (S_AXI_WDATA),
      .re    (mem_re),
      .raddr (S_AXI_ARADDR[2+DEPTH_LOG2-1:2]),
      .rdata (mem_rdata)
   );

   // Write FSM: address, data beats until WLAST, then hold response until BREADY
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_state <= WR_ADDR;
         wr_legal <= 1'b0;
         wr_word  <= '0;
         bresp    <= AXI_RESP_OKAY;
      end else begin
         case (wr_state)
            WR_ADDR: begin
               if (aw_hs) begin
                  wr_legal <= aw_legal;
                  wr_word  <= S_AXI_AWADDR[2+DEPTH_LOG2-1:2];
                  wr_state <= WR_DATA;
               end
            end
            WR_DATA: begin
               if (w_hs && S_AXI_WLAST) begin
                  bresp    <= wr_legal ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                  wr_state <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (b_hs) begin
                  wr_state <= WR_ADDR;
               end
            end
            default: wr_state <= WR_ADDR;
         endcase
      end
   end

   // Read FSM: one beat for legal reads, len+1 SLVERR beats for error bursts
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_state <= RD_ADDR;
         rd_legal <= 1'b0;
         rd_len   <= 8'd0;
         rd_cnt   <= 8'd0;
         rresp    <= AXI_RESP_OKAY;
         rlast    <= 1'b0;
      end else begin
         case (rd_state)
            RD_ADDR: begin
               if (ar_hs) begin
                  rd_legal <= ar_legal;
                  rd_len   <= S_AXI_ARLEN;
                  rd_cnt   <= 8'd0;
                  rresp    <= ar_legal ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                  rlast    <= (S_AXI_ARLEN == 8'd0);
                  rd_state <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (r_hs) begin
                  if (rlast) begin
                     rd_state <= RD_ADDR;
                  end else begin
                     // rlast stops the count at rd_len, so it never wraps
                     rd_cnt <= rd_cnt + 8'd1;
                     rlast  <= ((rd_cnt + 8'd1) == rd_len);
                  end
               end
            end
            default: rd_state <= RD_ADDR;
         endcase
      end
   end

endmodule

// File: tb/tb_armleocpu_axi_sram.sv
// Directed bench for the AXI SRAM responder: data path, strobes, error paths, stalls, collision, reset.
// Latency: checks AR->R of one cycle and AW->B of two cycles.
// Backpressure: holds BREADY/RREADY low to check response stability.
module tb_armleocpu_axi_sram;

   logic        clk;
   logic        rst_n;
   logic        S_AXI_AWVALID, S_AXI_AWREADY;
   logic [31:0] S_AXI_AWADDR;
   logic [7:0]  S_AXI_AWLEN;
   logic [2:0]  S_AXI_AWSIZE;
   logic [1:0]  S_AXI_AWBURST;
   logic        S_AXI_AWLOCK;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_WVALID, S_AXI_WREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WLAST;
   logic        S_AXI_BVALID, S_AXI_BREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BUSER;
   logic        S_AXI_ARVALID, S_AXI_ARREADY;
   logic [31:0] S_AXI_ARADDR;
   logic [7:0]  S_AXI_ARLEN;
   logic [2:0]  S_AXI_ARSIZE;
   logic [1:0]  S_AXI_ARBURST;
   logic        S_AXI_ARLOCK;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_RVALID, S_AXI_RREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RLAST;
   logic        S_AXI_RUSER;

   int n_assert = 0;
   int n_fail   = 0;

   armleocpu_axi_sram dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWLEN   (S_AXI_AWLEN),
      .S_AXI_AWSIZE  (S_AXI_AWSIZE),
      .S_AXI_AWBURST (S_AXI_AWBURST),
      .S_AXI_AWLOCK  (S_AXI_AWLOCK),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WLAST   (S_AXI_WLAST),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BUSER   (S_AXI_BUSER),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARLEN   (S_AXI_ARLEN),
      .S_AXI_ARSIZE  (S_AXI_ARSIZE),
      .S_AXI_ARBURST (S_AXI_ARBURST),
      .S_AXI_ARLOCK  (S_AXI_ARLOCK),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RLAST   (S_AXI_RLAST),
      .S_AXI_RUSER   (S_AXI_RUSER)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net in case a handshake never completes
   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [7:0] len, input int beats, input logic [1:0] exp_resp,
                           input string tag);
      int t;
      check({tag, "_wready_idle"}, S_AXI_WREADY, 1'b0);
      S_AXI_AWVALID = 1'b1;
      S_AXI_AWADDR  = addr;
      S_AXI_AWLEN   = len;
      S_AXI_AWSIZE  = 3'b010;
      t = 0;
      while (!S_AXI_AWREADY && t < 20) begin tick(); t++; end
      check({tag, "_awready"}, S_AXI_AWREADY, 1'b1);
      tick();
      S_AXI_AWVALID = 1'b0;
      for (int b = 0; b < beats; b++) begin
         S_AXI_WVALID = 1'b1;
         S_AXI_WDATA  = data;
         S_AXI_WSTRB  = strb;
         S_AXI_WLAST  = (b == beats - 1);
         t = 0;
         while (!S_AXI_WREADY && t < 20) begin tick(); t++; end
         check({tag, "_wready"}, S_AXI_WREADY, 1'b1);
         tick();
      end
      S_AXI_WVALID = 1'b0;
      S_AXI_WLAST  = 1'b0;
      check({tag, "_bvalid"}, S_AXI_BVALID, 1'b1);
      check({tag, "_bresp"}, S_AXI_BRESP, exp_resp);
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      check({tag, "_bvalid_done"}, S_AXI_BVALID, 1'b0);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
      check({tag, "_arready"}, S_AXI_ARREADY, 1'b1);
      check({tag, "_rvalid_idle"}, S_AXI_RVALID, 1'b0);
      S_AXI_ARVALID = 1'b1;
      S_AXI_ARADDR  = addr;
      S_AXI_ARLEN   = len;
      S_AXI_ARSIZE  = 3'b010;
      tick();
      S_AXI_ARVALID = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         check({tag, "_rvalid"}, S_AXI_RVALID, 1'b1);
         check({tag, "_rdata"}, S_AXI_RDATA, exp_data);
         check({tag, "_rresp"}, S_AXI_RRESP, exp_resp);
         check({tag, "_rlast"}, S_AXI_RLAST, (b == int'(len)));
         S_AXI_RREADY = 1'b1;
         tick();
         S_AXI_RREADY = 1'b0;
      end
      check({tag, "_rvalid_done"}, S_AXI_RVALID, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      S_AXI_AWVALID = 1'b0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = 3'b010;
      S_AXI_AWBURST = 2'b01; S_AXI_AWLOCK = 1'b0; S_AXI_AWPROT = '0;
      S_AXI_WVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARVALID = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'b010;
      S_AXI_ARBURST = 2'b01; S_AXI_ARLOCK = 1'b0; S_AXI_ARPROT = '0;
      S_AXI_RREADY = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_awready", S_AXI_AWREADY, 1'b0);
      check("rst_wready", S_AXI_WREADY, 1'b0);
      check("rst_bvalid", S_AXI_BVALID, 1'b0);
      check("rst_arready", S_AXI_ARREADY, 1'b0);
      check("rst_rvalid", S_AXI_RVALID, 1'b0);
      check("rst_bresp", S_AXI_BRESP, 2'b00);
      check("rst_rresp", S_AXI_RRESP, 2'b00);
      check("rst_rdata", S_AXI_RDATA, 32'h0);
      check("rst_rlast", S_AXI_RLAST, 1'b0);
      rst_n = 1'b1;
      tick();

      // Full word write and readback
      do_write(32'h8, 32'hDEADBEEF, 4'hF, 8'd0, 1, 2'b00, "w_full");
      do_read(32'h8, 8'd0, 32'hDEADBEEF, 2'b00, "r_full");

      // Strobed write merges bytes 0 and 2
      do_write(32'h8, 32'h11223344, 4'b0101, 8'd0, 1, 2'b00, "w_strb");
      do_read(32'h8, 8'd0, 32'hDE22BE44, 2'b00, "r_strb");

      // Out-of-range read and misaligned write
      do_read(32'h1000, 8'd0, 32'h0, 2'b10, "r_oor");
      do_write(32'h0, 32'h12345678, 4'hF, 8'd0, 1, 2'b00, "w_word0");
      do_write(32'h2, 32'hFFFFFFFF, 4'hF, 8'd0, 1, 2'b10, "w_misal");
      do_read(32'h0, 8'd0, 32'h12345678, 2'b00, "r_word0");

      // Error bursts
      do_read(32'h4, 8'd3, 32'h0, 2'b10, "r_burst");
      do_write(32'h8, 32'hCAFEF00D, 4'hF, 8'd1, 2, 2'b10, "w_burst");
      do_read(32'h8, 8'd0, 32'hDE22BE44, 2'b00, "r_after_burst");

      // Read response stalled by RREADY low
      S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = 32'h8; S_AXI_ARLEN = 8'd0;
      tick();
      S_AXI_ARVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("rstall_rvalid", S_AXI_RVALID, 1'b1);
         check("rstall_rdata", S_AXI_RDATA, 32'hDE22BE44);
         check("rstall_rresp", S_AXI_RRESP, 2'b00);
         tick();
      end
      S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_RREADY = 1'b0;
      check("rstall_done", S_AXI_RVALID, 1'b0);

      // Error write response stalled by BREADY low
      S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 32'h1000; S_AXI_AWLEN = 8'd0;
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID = 1'b1; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bstall_bvalid", S_AXI_BVALID, 1'b1);
         check("bstall_bresp", S_AXI_BRESP, 2'b10);
         tick();
      end
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      check("bstall_done", S_AXI_BVALID, 1'b0);
      check("bstall_awready", S_AXI_AWREADY, 1'b1);

      // Same-cycle write and AR to one word returns the old data
      do_write(32'h10, 32'h0, 4'hF, 8'd0, 1, 2'b00, "w_clear");
      S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 32'h10; S_AXI_AWLEN = 8'd0;
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID = 1'b1; S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b1;
      S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = 32'h10; S_AXI_ARLEN = 8'd0;
      tick();
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; S_AXI_ARVALID = 1'b0;
      check("coll_rvalid", S_AXI_RVALID, 1'b1);
      check("coll_rdata_old", S_AXI_RDATA, 32'h0);
      check("coll_bvalid", S_AXI_BVALID, 1'b1);
      check("coll_bresp", S_AXI_BRESP, 2'b00);
      S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
      do_read(32'h10, 8'd0, 32'hA5A5A5A5, 2'b00, "coll_new");

      // Reset in the middle of a write drops it
      S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 32'h14; S_AXI_AWLEN = 8'd0;
      tick();
      S_AXI_AWVALID = 1'b0;
      check("mrst_wready_pre", S_AXI_WREADY, 1'b1);
      rst_n = 1'b0;
      tick();
      check("mrst_awready", S_AXI_AWREADY, 1'b0);
      check("mrst_wready", S_AXI_WREADY, 1'b0);
      check("mrst_bvalid", S_AXI_BVALID, 1'b0);
      rst_n = 1'b1;
      tick();
      check("mrst_awready_back", S_AXI_AWREADY, 1'b1);
      check("mrst_wready_back", S_AXI_WREADY, 1'b0);
      check("mrst_bvalid_back", S_AXI_BVALID, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
